// File: rtl/rf_pkg.sv
// Shared encodings for the multiport register file: write modes and
// clear-sweep controller states.
package rf_pkg;

    typedef enum logic [1:0] {
        WM_FULL = 2'b00,
        WM_LO   = 2'b01,
        WM_HI   = 2'b10,
        WM_RSVD = 2'b11
    } wr_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/rf_wr_merge.sv
// Combinational merge of an existing entry with write data according to the
// write mode; shared by the array write and the read bypass path.
module rf_wr_merge
    import rf_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] old_val,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        wr_mode,
    output logic [DATA_W-1:0] new_val
);

    localparam int HALF_W = DATA_W / 2;

    // Half modes always source the low half of wr_data.
    always_comb begin
        new_val = old_val;
        case (wr_mode)
            WM_FULL: new_val = wr_data;
            WM_LO:   new_val[HALF_W-1:0] = wr_data[HALF_W-1:0];
            WM_HI:   new_val[DATA_W-1:HALF_W] = wr_data[HALF_W-1:0];
            default: new_val = old_val;
        endcase
    end

endmodule

// File: rtl/rf_multiport.sv
// Parametrised register file with NRD registered read ports, half-word writes,
// write-to-read bypass and a sequential clear sweep.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int NRD    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [1:0]            wr_mode,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    state_e            state, next_state;
    logic [ADDR_W-1:0] idx, next_idx;
    logic              wr_valid;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rd_next [NRD];

    assign busy     = (state == ST_CLEAR);
    assign wr_valid = wr_en && (state == ST_IDLE) && (wr_mode != WM_RSVD);

    rf_wr_merge #(.DATA_W(DATA_W)) u_merge (
        .old_val (mem[wr_addr]),
        .wr_data (wr_data),
        .wr_mode (wr_mode),
        .new_val (merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_CLEAR;
            idx   <= '0;
        end else begin
            state <= next_state;
            idx   <= next_idx;
        end
    end

    // A clear request restarts the sweep from entry 0 in either state.
    always_comb begin
        next_state = state;
        next_idx   = idx;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    next_state = ST_CLEAR;
                    next_idx   = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_req) begin
                    next_idx = '0;
                end else if (idx == {ADDR_W{1'b1}}) begin
                    next_state = ST_IDLE;
                    next_idx   = '0;
                end else begin
                    next_idx = idx + ADDR_W'(1);
                end
            end
            default: begin
                next_state = ST_CLEAR;
                next_idx   = '0;
            end
        endcase
    end

    // The array is left untouched during the reset cycle itself.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[idx] <= '0;
            end else if (wr_valid) begin
                mem[wr_addr] <= merged;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rd_next[k] = '0;
            if (state == ST_IDLE) begin
                if (wr_valid && (wr_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
                    rd_next[k] = merged;
                end else begin
                    rd_next[k] = mem[rd_addr[k*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_en && ((state == ST_CLEAR) || (wr_mode == WM_RSVD));
            for (int k = 0; k < NRD; k++) begin
                if (rd_en[k]) begin
                    rd_data[k*DATA_W +: DATA_W] <= rd_next[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Randomised and directed bench for rf_multiport against a behavioural model
// of the register file contents, sweep progress and drop pulses.
module tb_rf_multiport;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int NRD    = 3;
    localparam int DEPTH  = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NRD-1:0]        rd_en;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic                  wr_en;
    logic [1:0]            wr_mode;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  clr_req;
    logic                  busy;
    logic                  wr_drop;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    logic [DATA_W-1:0] mm [DEPTH];
    logic [DATA_W-1:0] exp_rd [NRD];
    int                clear_left;
    logic              exp_busy;
    logic              exp_drop;

    rf_multiport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_mode (wr_mode),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .clr_req (clr_req),
        .busy    (busy),
        .wr_drop (wr_drop)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] spec_merge(input logic [31:0] old_v,
                                               input logic [31:0] d,
                                               input logic [1:0] m);
        case (m)
            2'd0:    return d;
            2'd1:    return {old_v[31:16], d[15:0]};
            2'd2:    return {d[15:0], old_v[15:0]};
            default: return old_v;
        endcase
    endfunction

    // Advances the model by one rising edge using the inputs currently applied.
    task automatic model_step();
        bit          clearing;
        bit          valid;
        logic [31:0] nv;
        logic [3:0]  a;
        if (reset) begin
            for (int k = 0; k < NRD; k++) exp_rd[k] = '0;
            exp_drop   = 1'b0;
            clear_left = DEPTH;
            exp_busy   = 1'b1;
            return;
        end
        clearing = (clear_left > 0);
        valid    = wr_en && !clearing && (wr_mode != 2'd3);
        nv       = spec_merge(mm[wr_addr], wr_data, wr_mode);
        for (int k = 0; k < NRD; k++) begin
            a = rd_addr[k*ADDR_W +: ADDR_W];
            if (rd_en[k]) begin
                if (clearing) exp_rd[k] = '0;
                else if (valid && a == wr_addr) exp_rd[k] = nv;
                else exp_rd[k] = mm[a];
            end
        end
        exp_drop = wr_en && (clearing || wr_mode == 2'd3);
        if (clearing) begin
            mm[DEPTH - clear_left] = '0;
            clear_left = clr_req ? DEPTH : clear_left - 1;
        end else begin
            if (valid) mm[wr_addr] = nv;
            if (clr_req) clear_left = DEPTH;
        end
        exp_busy = (clear_left > 0);
    endtask

    task automatic checkLiteral(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic checkOutput();
        n_checks++;
        if (busy !== exp_busy) begin
            n_fail++;
            $display("[TB] FAIL busy @%0t: got %b, expected %b", $time, busy, exp_busy);
        end
        n_checks++;
        if (wr_drop !== exp_drop) begin
            n_fail++;
            $display("[TB] FAIL wr_drop @%0t: got %b, expected %b", $time, wr_drop, exp_drop);
        end
        for (int k = 0; k < NRD; k++) begin
            n_checks++;
            if (rd_data[k*DATA_W +: DATA_W] !== exp_rd[k]) begin
                n_fail++;
                $display("[TB] FAIL rd_data[%0d] @%0t: got %h, expected %h",
                         k, $time, rd_data[k*DATA_W +: DATA_W], exp_rd[k]);
            end
        end
    endtask

    always @(negedge clk) begin
        if (check_en) checkOutput();
    end

    task automatic applyStimulus(input logic rst, input logic [2:0] ren,
                                 input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                                 input logic we, input logic [1:0] wm, input logic [3:0] wa,
                                 input logic [31:0] wd, input logic clr);
        reset   = rst;
        rd_en   = ren;
        rd_addr = {a2, a1, a0};
        wr_en   = we;
        wr_mode = wm;
        wr_addr = wa;
        wr_data = wd;
        clr_req = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0);
    endtask

    function automatic logic [31:0] port(input int k);
        return rd_data[k*DATA_W +: DATA_W];
    endfunction

    task automatic readAllZero(input string name);
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b0, 3'b111, 4'(a), 4'(a), 4'(a), 1'b0, 2'd0, 4'd0, 32'd0, 1'b0);
            checkLiteral(name, port(0), 32'h0);
        end
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        @(negedge clk);
        applyStimulus(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0);
        check_en = 1'b1;
        applyStimulus(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0);
        checkLiteral("reset_busy", 32'(busy), 32'd1);
        checkLiteral("reset_rd", port(1), 32'h0);

        // Initial sweep with a write to r7 attempted partway through.
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            if (cnt == 3) begin
                applyStimulus(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 4'd7, 32'h55, 1'b0);
                checkLiteral("drop_in_sweep", 32'(wr_drop), 32'd1);
            end else begin
                idle();
            end
            cnt++;
        end
        checkLiteral("sweep_len", 32'(cnt), 32'd16);
        readAllZero("after_sweep");

        applyStimulus(1'b0, 3'b100, 4'd0, 4'd0, 4'd5, 1'b1, 2'd0, 4'd5, 32'hDEADBEEF, 1'b0);
        checkLiteral("bypass_full", port(2), 32'hDEADBEEF);
        applyStimulus(1'b0, 3'b111, 4'd5, 4'd5, 4'd5, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0);
        checkLiteral("r5_p0", port(0), 32'hDEADBEEF);
        checkLiteral("r5_p1", port(1), 32'hDEADBEEF);
        checkLiteral("r5_p2", port(2), 32'hDEADBEEF);

        applyStimulus(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 2'd0, 4'd3, 32'h11112222, 1'b0);
        applyStimulus(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 2'd2, 4'd3, 32'h0000ABCD, 1'b0);
        applyStimulus(1'b0, 3'b001, 4'd3, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0);
        checkLiteral("half_hi", port(0), 32'hABCD2222);
        applyStimulus(1'b0, 3'b010, 4'd0, 4'd3, 4'd0, 1'b1, 2'd1, 4'd3, 32'h00001234, 1'b0);
        checkLiteral("half_lo_bypass", port(1), 32'hABCD1234);

        applyStimulus(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 2'd3, 4'd3, 32'hFFFFFFFF, 1'b0);
        checkLiteral("drop_rsvd", 32'(wr_drop), 32'd1);
        applyStimulus(1'b0, 3'b001, 4'd3, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0);
        checkLiteral("rsvd_unchanged", port(0), 32'hABCD1234);
        checkLiteral("drop_clears", 32'(wr_drop), 32'd0);

        applyStimulus(1'b0, 3'b111, 4'd5, 4'd5, 4'd5, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 3'b101, 4'd3, 4'd0, 4'd3, 1'b0, 2'd0, 4'd0, 32'd0, 1'b0);
        checkLiteral("hold_p1", port(1), 32'hDEADBEEF);
        checkLiteral("upd_p0", port(0), 32'hABCD1234);
        checkLiteral("upd_p2", port(2), 32'hABCD1234);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'b0, 3'($urandom_range(0, 7)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                          32'($urandom), 1'($urandom_range(0, 59) == 0));
        end

        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            idle();
            cnt++;
        end
        checkLiteral("drain_busy", 32'(busy), 32'd0);

        // Restart the sweep when it has reached entry 9.
        applyStimulus(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0, 32'd0, 1'b1);
        for (int i = 0; i < 9; i++) idle();
        applyStimulus(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 2'd0, 4'd0, 32'd0, 1'b1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            idle();
            cnt++;
        end
        checkLiteral("restart_len", 32'(cnt), 32'd16);
        readAllZero("after_restart");

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised successor register file for the CPU datapath.
- Generalises data width, depth and read-port count.
- Adds per-port read enables, half-word write modes and write-to-read bypass.
- Adds a sequential clear sweep (state machine) started by reset or by request.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
- DATA_W, 32, register width in bits; must be even.
- ADDR_W, 4, address width; depth = 2**ADDR_W.
- NRD, 3, number of read ports.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_en  in  NRD  per-port read enable.
- rd_addr  in  NRD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NRD*DATA_W  registered read data; port k at bits [k*DATA_W +: DATA_W].
- wr_en  in  1  write request.
- wr_mode  in  2  write mode: 00 full word, 01 low half, 10 high half, 11 reserved.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data; half modes use wr_data[DATA_W/2-1:0] as the source half.
- clr_req  in  1  single-cycle request to restart the clear sweep.
- busy  out  1  clear sweep in progress.
- wr_drop  out  1  one-cycle pulse: a write was discarded (busy, or mode 11).

Behaviour:
- Reset (sampled at posedge):
  - rd_data = 0, wr_drop = 0, busy = 1.
  - FSM = CLEAR, sweep index = 0.
  - Array contents are not touched in the reset cycle itself.
- FSM CLEAR:
  - Each cycle, writes 0 to entry[idx], then idx++.
  - After entry 2**ADDR_W-1 is cleared, the next state is IDLE and busy falls the same edge.
  - Sweep length: exactly 2**ADDR_W cycles after reset deasserts.
  - clr_req during CLEAR restarts the sweep at idx 0.
- FSM IDLE: clr_req -> CLEAR at idx 0; busy = 1 from the next edge.
- Reads:
  - Latency is one cycle: rd_data[k] at edge N+1 reflects rd_addr[k] sampled at edge N when rd_en[k] = 1.
  - rd_en[k] = 0: rd_data[k] holds its value.
  - During CLEAR: an enabled port loads 0.
- Writes (IDLE only):
  - Mode 00: whole entry <= wr_data.
  - Mode 01: low half <= wr_data low half; high half kept.
  - Mode 10: high half <= wr_data low half; low half kept.
  - Mode 11: no write; wr_drop pulses.
  - wr_en during CLEAR: no write; wr_drop = 1 on the next cycle.
- Bypass:
  - Condition: same-cycle enabled read and valid write to the same address.
  - rd_data gets the merged post-write value, not the stale entry.
  - Applies to all ports independently.
  - No bypass for dropped writes.
- Multiple read ports may address the same entry; all return identical data.
- Address 0 is an ordinary writable register, not hardwired to zero.
- clr_req together with wr_en in IDLE: the write is performed, then the sweep starts next cycle and clears it.

Decomposition:
- Shared package rf_pkg:
  - wr_mode encodings: WM_FULL, WM_LO, WM_HI, WM_RSVD.
  - FSM state encoding: ST_IDLE, ST_CLEAR.
- One sub-module, rf_wr_merge: combinational merge of old entry, wr_data and wr_mode into the new entry value.
  - Reused by both the array write and the bypass path.

Test Plan:
- Reset for 2 cycles, then release -> busy = 1 for exactly 16 cycles (default params), then 0; reads of all 16 addresses return 0.
- Full-word write and bypass:
  - Write 0xDEADBEEF to r5, mode 00.
  - Next cycle, read r5 on all 3 ports -> all return 0xDEADBEEF one cycle later.
  - Same-cycle read of r5 during that write -> bypassed 0xDEADBEEF.
- Half-word writes:
  - r3 = 0x11112222; write mode 10 with wr_data = 0x0000ABCD -> r3 reads 0xABCD2222.
  - Then mode 01 with 0x00001234 -> r3 reads 0xABCD1234.
- Dropped writes:
  - Write 0x55 to r7 during sweep -> wr_drop pulses; r7 reads 0 after sweep.
  - Mode 11 write in IDLE -> wr_drop pulses; entry unchanged.
- Hold: rd_en[1] = 0 while rd_addr[1] changes -> rd_data[1] holds its previous value; ports 0 and 2 update.
- Restart: clr_req at sweep index 9 -> busy stays 1 for 16 further cycles; all entries read 0 afterwards.
